// File: rtl/tlp_tx_hdr_arbiter.sv
// tlp_tx_hdr_arbiter: arbitrates request TLPs, checks PH/NPH credits, allocates NP tags and serialises 3DW/4DW headers.
// Define TLP_TX_FIXED_PRIO_EN for fixed lowest-index priority instead of round robin.
module tlp_tx_hdr_arbiter #(
   parameter int NUM_REQ = 4,
   parameter int CRED_W  = 8,
   parameter int TAG_MAX = 255
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [NUM_REQ-1:0]    req_valid,
   output logic [NUM_REQ-1:0]    req_ready,
   input  logic [NUM_REQ-1:0]    req_np,
   input  logic [3*NUM_REQ-1:0]  req_fmt,
   input  logic [5*NUM_REQ-1:0]  req_type,
   input  logic [10*NUM_REQ-1:0] req_length,
   input  logic [8*NUM_REQ-1:0]  req_be,
   input  logic [64*NUM_REQ-1:0] req_addr,
   input  logic                  ari_enabled,
   input  logic [7:0]            bus_num,
   input  logic [4:0]            device_num,
   input  logic [2:0]            fnc_num,
   input  logic [7:0]            ari_fnc_num,
   input  logic [CRED_W-1:0]     fc_ph_limit,
   input  logic [CRED_W-1:0]     fc_nph_limit,
   output logic [31:0]           tx_dw_data,
   output logic                  tx_dw_valid,
   input  logic                  tx_dw_ready,
   output logic                  tx_dw_sop,
   output logic                  tx_dw_eop,
   output logic                  tx_is_4dw
);
   localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam logic [CRED_W-1:0] HALF = {1'b1, {(CRED_W-1){1'b0}}};
   typedef enum logic [2:0] {IDLE, DW0, DW1, DW2, DW3} state_t;
   state_t state, nxt;
   logic [IW-1:0] gnt;
   logic found, take, ph_ok, nph_ok;
   logic [CRED_W-1:0] ph_cnt, nph_cnt, ph_av, nph_av;
   logic [NUM_REQ-1:0] elig;
   logic [7:0] tag_cnt, tag_q, be_q;
   logic [2:0] fmt_q;
   logic [4:0] type_q;
   logic [9:0] len_q;
   logic [63:0] addr_q;
   logic [15:0] rid_q;
   // available credit is treated as a signed window: wrapped-negative values block
   assign ph_av  = fc_ph_limit - ph_cnt;
   assign nph_av = fc_nph_limit - nph_cnt;
   assign ph_ok  = (ph_av != '0) && (ph_av <= HALF);
   assign nph_ok = (nph_av != '0) && (nph_av <= HALF);
   assign elig   = req_valid & ((req_np & {NUM_REQ{nph_ok}}) | (~req_np & {NUM_REQ{ph_ok}}));
   assign take   = (state == IDLE) && found;
`ifdef TLP_TX_FIXED_PRIO_EN
   function automatic logic [IW-1:0] cand(input int k);
      return IW'(k);
   endfunction
`else
   logic [IW-1:0] ptr;
   function automatic logic [IW-1:0] cand(input int k);
      int s = int'(ptr) + 1 + k;
      return IW'((s >= NUM_REQ) ? s - NUM_REQ : s);
   endfunction
   always_ff @(posedge clk)
      if (!rst) ptr <= IW'(NUM_REQ - 1);
      else if (take) ptr <= gnt;
`endif
   always_comb begin
      found = 1'b0;
      gnt = '0;
      for (int k = 0; k < NUM_REQ; k++)
         if (!found && elig[cand(k)]) begin
            found = 1'b1;
            gnt = cand(k);
         end
   end
   always_ff @(posedge clk)
      if (!rst) state <= IDLE;
      else state <= nxt;
   always_comb begin
      nxt = state;
      req_ready = '0;
      tx_dw_valid = 1'b0;
      tx_dw_sop = 1'b0;
      tx_dw_eop = 1'b0;
      tx_dw_data = '0;
      case (state)
         IDLE: if (found) begin
            nxt = DW0;
            req_ready[gnt] = rst;
         end
         DW0: begin
            tx_dw_valid = 1'b1;
            tx_dw_sop = 1'b1;
            tx_dw_data = {fmt_q, type_q, 14'b0, len_q};
            if (tx_dw_ready) nxt = DW1;
         end
         DW1: begin
            tx_dw_valid = 1'b1;
            tx_dw_data = {rid_q, tag_q, be_q};
            if (tx_dw_ready) nxt = DW2;
         end
         DW2: begin
            tx_dw_valid = 1'b1;
            tx_dw_eop = !fmt_q[0];
            tx_dw_data = fmt_q[0] ? addr_q[63:32] : {addr_q[31:2], 2'b00};
            if (tx_dw_ready) nxt = fmt_q[0] ? DW3 : IDLE;
         end
         DW3: begin
            tx_dw_valid = 1'b1;
            tx_dw_eop = 1'b1;
            tx_dw_data = {addr_q[31:2], 2'b00};
            if (tx_dw_ready) nxt = IDLE;
         end
         default: nxt = IDLE;
      endcase
   end
   assign tx_is_4dw = (state != IDLE) && fmt_q[0];
   always_ff @(posedge clk)
      if (!rst) begin
         ph_cnt <= '0;
         nph_cnt <= '0;
         tag_cnt <= '0;
         tag_q <= '0;
         fmt_q <= '0;
         type_q <= '0;
         len_q <= '0;
         be_q <= '0;
         addr_q <= '0;
         rid_q <= '0;
      end else if (take) begin
         fmt_q <= req_fmt[3*gnt +: 3];
         type_q <= req_type[5*gnt +: 5];
         len_q <= req_length[10*gnt +: 10];
         be_q <= req_be[8*gnt +: 8];
         addr_q <= req_addr[64*gnt +: 64];
         rid_q <= ari_enabled ? {bus_num, ari_fnc_num} : {bus_num, device_num, fnc_num};
         if (req_np[gnt]) begin
            nph_cnt <= nph_cnt + CRED_W'(1);
            tag_q <= tag_cnt;
            tag_cnt <= (tag_cnt == 8'(TAG_MAX)) ? 8'd0 : tag_cnt + 8'd1;
         end else begin
            ph_cnt <= ph_cnt + CRED_W'(1);
            tag_q <= '0;
         end
      end
endmodule

// File: tb/tb_tlp_tx_hdr_arbiter.sv
// tb_tlp_tx_hdr_arbiter: table of single-request header vectors plus round-robin, credit,
// backpressure and mid-TLP reset sequences.
`timescale 1ns/1ps
module tb_tlp_tx_hdr_arbiter;
   localparam int N = 4;
   logic clk = 1'b0;
   logic rst = 1'b0;
   logic [N-1:0] req_valid = '0, req_np = '0, req_ready;
   logic [3*N-1:0] req_fmt = '0;
   logic [5*N-1:0] req_type = '0;
   logic [10*N-1:0] req_length = '0;
   logic [8*N-1:0] req_be = '0;
   logic [64*N-1:0] req_addr = '0;
   logic ari_enabled = 1'b0;
   logic [7:0] bus_num = '0, ari_fnc_num = '0;
   logic [4:0] device_num = '0;
   logic [2:0] fnc_num = '0;
   logic [7:0] fc_ph_limit = 8'h40, fc_nph_limit = 8'h40;
   logic [31:0] tx_dw_data;
   logic tx_dw_valid, tx_dw_sop, tx_dw_eop, tx_is_4dw;
   logic tx_dw_ready = 1'b1;

   tlp_tx_hdr_arbiter dut (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_np(req_np),
      .req_fmt(req_fmt), .req_type(req_type), .req_length(req_length), .req_be(req_be),
      .req_addr(req_addr), .ari_enabled(ari_enabled), .bus_num(bus_num), .device_num(device_num),
      .fnc_num(fnc_num), .ari_fnc_num(ari_fnc_num), .fc_ph_limit(fc_ph_limit),
      .fc_nph_limit(fc_nph_limit), .tx_dw_data(tx_dw_data), .tx_dw_valid(tx_dw_valid),
      .tx_dw_ready(tx_dw_ready), .tx_dw_sop(tx_dw_sop), .tx_dw_eop(tx_dw_eop), .tx_is_4dw(tx_is_4dw)
   );

   always #5 clk = ~clk;

   typedef struct {
      int r;
      logic np;
      logic [2:0] fmt;
      logic [4:0] typ;
      logic [9:0] len;
      logic [7:0] be;
      logic [63:0] addr;
      logic ari;
      logic [7:0] bus;
      logic [4:0] dev;
      logic [2:0] fn;
      logic [7:0] afn;
      int n;
      logic [31:0] e0, e1, e2, e3;
   } vec_t;

   vec_t tv[6];
   int n_chk = 0, n_err = 0;
   int g, n, exp_g;
   logic [3:0][31:0] d, ex;
   logic [3:0] sop, eop;
   logic is4;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h want %0h", name, act, exp);
      end
   endtask

   task automatic set_req(input int r, input logic np, input logic [2:0] fmt, input logic [4:0] typ,
                          input logic [9:0] len, input logic [7:0] be, input logic [63:0] addr);
      req_np[r] = np;
      req_fmt[3*r +: 3] = fmt;
      req_type[5*r +: 5] = typ;
      req_length[10*r +: 10] = len;
      req_be[8*r +: 8] = be;
      req_addr[64*r +: 64] = addr;
      req_valid[r] = 1'b1;
   endtask

   task automatic do_reset;
      rst = 1'b0;
      req_valid = '0;
      tx_dw_ready = 1'b1;
      repeat (2) @(negedge clk);
      #1 chk("reset_out", {req_ready, tx_dw_valid, tx_dw_sop, tx_dw_eop, tx_is_4dw, tx_dw_data}, 0);
      rst = 1'b1;
      @(negedge clk);
   endtask

   // waits for a grant, optionally drops that requester, then collects header DWs up to eop
   task automatic run_tlp(input logic drop, output int gi, output int ni, output logic [3:0][31:0] dd,
                          output logic [3:0] so, output logic [3:0] eo, output logic f4);
      gi = -1;
      ni = 0;
      dd = '0;
      so = '0;
      eo = '0;
      f4 = 1'b0;
      for (int c = 0; c < 40 && gi < 0; c++) begin
         #1;
         for (int i = 0; i < N; i++) if (req_ready[i]) gi = i;
         @(negedge clk);
      end
      if (gi < 0) begin
         n_chk++;
         n_err++;
         $display("FAIL grant_timeout: got no grant want a grant within 40 cycles");
         return;
      end
      if (drop) req_valid[gi] = 1'b0;
      for (int c = 0; c < 40; c++) begin
         #1;
         if (tx_dw_valid && tx_dw_ready && ni < 4) begin
            dd[ni] = tx_dw_data;
            so[ni] = tx_dw_sop;
            eo[ni] = tx_dw_eop;
            f4 = tx_is_4dw;
            ni++;
         end
         @(negedge clk);
         if (ni > 0 && eo[ni-1]) break;
      end
   endtask

   initial begin
      tv[0] = '{r:0, np:1'b0, fmt:3'b010, typ:5'd0, len:10'd4, be:8'hFF, addr:64'h1000_0000, ari:1'b0,
                bus:8'h01, dev:5'd2, fn:3'd3, afn:8'h00, n:3,
                e0:32'h4000_0004, e1:32'h0113_00FF, e2:32'h1000_0000, e3:32'h0};
      tv[1] = '{r:1, np:1'b1, fmt:3'b001, typ:5'd0, len:10'd1, be:8'h0F, addr:64'h1_2345_6788, ari:1'b1,
                bus:8'h01, dev:5'd0, fn:3'd0, afn:8'hA5, n:4,
                e0:32'h2000_0001, e1:32'h01A5_000F, e2:32'h0000_0001, e3:32'h2345_6788};
      tv[2] = '{r:1, np:1'b1, fmt:3'b001, typ:5'd0, len:10'd1, be:8'h0F, addr:64'h1_2345_6788, ari:1'b1,
                bus:8'h01, dev:5'd0, fn:3'd0, afn:8'hA5, n:4,
                e0:32'h2000_0001, e1:32'h01A5_010F, e2:32'h0000_0001, e3:32'h2345_6788};
      tv[3] = '{r:2, np:1'b1, fmt:3'b000, typ:5'd0, len:10'd2, be:8'hFF, addr:64'hABCD_EF07, ari:1'b0,
                bus:8'h12, dev:5'h1F, fn:3'd7, afn:8'h00, n:3,
                e0:32'h0000_0002, e1:32'h12FF_02FF, e2:32'hABCD_EF04, e3:32'h0};
      tv[4] = '{r:3, np:1'b0, fmt:3'b011, typ:5'd0, len:10'h3FF, be:8'hF0, addr:64'hFFFF_FFFF_0000_0013,
                ari:1'b1, bus:8'hFF, dev:5'd0, fn:3'd0, afn:8'h00, n:4,
                e0:32'h6000_03FF, e1:32'hFF00_00F0, e2:32'hFFFF_FFFF, e3:32'h0000_0010};
      tv[5] = '{r:0, np:1'b0, fmt:3'b001, typ:5'b10100, len:10'd0, be:8'h00, addr:64'h2_8000_0004,
                ari:1'b0, bus:8'h01, dev:5'd2, fn:3'd3, afn:8'h00, n:4,
                e0:32'h3400_0000, e1:32'h0113_0000, e2:32'h0000_0002, e3:32'h8000_0004};

      do_reset;
      for (int v = 0; v < 6; v++) begin
         ari_enabled = tv[v].ari;
         bus_num = tv[v].bus;
         device_num = tv[v].dev;
         fnc_num = tv[v].fn;
         ari_fnc_num = tv[v].afn;
         set_req(tv[v].r, tv[v].np, tv[v].fmt, tv[v].typ, tv[v].len, tv[v].be, tv[v].addr);
         run_tlp(1'b1, g, n, d, sop, eop, is4);
         ex = {tv[v].e3, tv[v].e2, tv[v].e1, tv[v].e0};
         chk($sformatf("v%0d_grant", v), g, tv[v].r);
         chk($sformatf("v%0d_ndw", v), n, tv[v].n);
         for (int k = 0; k < tv[v].n; k++) chk($sformatf("v%0d_dw%0d", v, k), d[k], ex[k]);
         chk($sformatf("v%0d_sop", v), sop, 4'b0001);
         chk($sformatf("v%0d_eop", v), eop, 4'b0001 << (tv[v].n - 1));
         chk($sformatf("v%0d_4dw", v), is4, tv[v].n == 4);
      end

      // round robin with all four requesters held valid
      do_reset;
      ari_enabled = 1'b0;
      bus_num = 8'h01;
      device_num = 5'd2;
      fnc_num = 3'd3;
      for (int i = 0; i < N; i++) set_req(i, 1'b0, 3'b010, 5'd0, 10'd1, 8'h0F, 64'h1000_0000 + 64'(i * 16));
      for (int k = 0; k < 5; k++) begin
         run_tlp(1'b0, g, n, d, sop, eop, is4);
`ifdef TLP_TX_FIXED_PRIO_EN
         exp_g = 0;
`else
         exp_g = k % N;
`endif
         chk($sformatf("rr_grant%0d", k), g, exp_g);
         chk($sformatf("rr_addr%0d", k), d[2], 32'h1000_0000 + 32'(exp_g * 16));
      end
      req_valid = '0;

      // NPH credit exhaustion lets the posted request through, then a raised limit frees NP
      fc_nph_limit = 8'd2;
      do_reset;
      set_req(0, 1'b1, 3'b000, 5'd0, 10'd1, 8'h0F, 64'h100);
      set_req(1, 1'b1, 3'b000, 5'd0, 10'd1, 8'h0F, 64'h200);
      set_req(2, 1'b0, 3'b010, 5'd0, 10'd1, 8'h0F, 64'h300);
      for (int k = 0; k < 3; k++) begin
         run_tlp(k == 2, g, n, d, sop, eop, is4);
`ifdef TLP_TX_FIXED_PRIO_EN
         exp_g = (k == 2) ? 2 : 0;
`else
         exp_g = k;
`endif
         chk($sformatf("cred_grant%0d", k), g, exp_g);
         chk($sformatf("cred_tag%0d", k), d[1][15:8], (k == 2) ? 0 : k);
      end
      for (int c = 0; c < 4; c++) begin
         #1 chk("cred_blocked", {req_ready, tx_dw_valid}, 0);
         @(negedge clk);
      end
      fc_nph_limit = 8'd3;
      run_tlp(1'b1, g, n, d, sop, eop, is4);
      chk("cred_grant3", g, 0);
      chk("cred_tag3", d[1][15:8], 2);
      req_valid = '0;
      fc_nph_limit = 8'h40;

      // backpressure on DW1
      do_reset;
      ari_enabled = 1'b0;
      bus_num = 8'h01;
      device_num = 5'd2;
      fnc_num = 3'd3;
      set_req(0, 1'b0, 3'b010, 5'd0, 10'd4, 8'hFF, 64'h1000_0000);
      #1 chk("bp_grant", req_ready, 4'b0001);
      @(negedge clk);
      #1 chk("bp_dw0", {tx_dw_valid, tx_dw_sop, tx_dw_data}, {2'b11, 32'h4000_0004});
      @(negedge clk);
      tx_dw_ready = 1'b0;
      for (int c = 0; c < 5; c++) begin
         #1 chk($sformatf("bp_hold%0d", c), {tx_dw_valid, tx_dw_sop, tx_dw_eop, req_ready, tx_dw_data},
                {3'b100, 4'b0000, 32'h0113_00FF});
         @(negedge clk);
      end
      tx_dw_ready = 1'b1;
      #1 chk("bp_release", {tx_dw_valid, tx_dw_data}, {1'b1, 32'h0113_00FF});
      @(negedge clk);
      #1 chk("bp_dw2", {tx_dw_valid, tx_dw_eop, req_ready, tx_dw_data}, {2'b11, 4'b0000, 32'h1000_0000});
      req_valid = '0;
      @(negedge clk);
      #1 chk("bp_idle", tx_dw_valid, 1'b0);
      @(negedge clk);

      // reset in the middle of a 4DW header
      fc_nph_limit = 8'd2;
      do_reset;
      ari_enabled = 1'b1;
      bus_num = 8'h01;
      ari_fnc_num = 8'hA5;
      set_req(1, 1'b1, 3'b001, 5'd0, 10'd1, 8'h0F, 64'h1_2345_6788);
      run_tlp(1'b1, g, n, d, sop, eop, is4);
      chk("rst_pre_tag", d[1][15:8], 0);
      set_req(1, 1'b1, 3'b001, 5'd0, 10'd1, 8'h0F, 64'h1_2345_6788);
      #1 chk("rst_grant", req_ready, 4'b0010);
      @(negedge clk);
      req_valid = '0;
      @(negedge clk);
      #1 chk("rst_dw1", tx_dw_data, 32'h01A5_010F);
      @(negedge clk);
      #1 chk("rst_dw2", {tx_dw_valid, tx_dw_eop, tx_dw_data}, {2'b10, 32'h0000_0001});
      rst = 1'b0;
      @(negedge clk);
      #1 chk("rst_abort", {tx_dw_valid, tx_dw_sop, tx_dw_eop, tx_is_4dw, req_ready}, 0);
      rst = 1'b1;
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
         set_req(1, 1'b1, 3'b001, 5'd0, 10'd1, 8'h0F, 64'h1_2345_6788);
         run_tlp(1'b1, g, n, d, sop, eop, is4);
         chk($sformatf("rst_post_grant%0d", k), g, 1);
         chk($sformatf("rst_post_tag%0d", k), d[1][15:8], k);
      end
      req_valid = '0;

      $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
      $finish;
   end
endmodule

// File: doc/tlp_tx_hdr_arbiter.md
Name: tlp_tx_hdr_arbiter

Overview:
- Arbitrates between NUM_REQ request-TLP sources (memory, IO, config, message) that share one transmit header path.
- Checks posted and non-posted header flow-control credits and allocates tags for non-posted requests.
- Builds the 3DW or 4DW PCIe request header, including the ARI or non-ARI Requester ID.
- Serialises the header as 32-bit DWs toward the TLP transmit datapath. Payload is not handled here; it is moved by the downstream data mux.

Parameters:
- NUM_REQ, 4: number of requesters, 2..8.
- CRED_W, 8: width of the header credit counters.
- TAG_MAX, 255: highest non-posted tag value; the tag counter wraps from TAG_MAX to 0.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-low reset.
- req_valid  in  NUM_REQ  request pending, one bit per requester.
- req_ready  out  NUM_REQ  grant/accept pulse, one cycle.
- req_np  in  NUM_REQ  1 = non-posted, 0 = posted (MWr, Msg).
- req_fmt  in  3*NUM_REQ  Fmt field.
- req_type  in  5*NUM_REQ  Type field.
- req_length  in  10*NUM_REQ  Length in DW.
- req_be  in  8*NUM_REQ  {last BE, first BE}.
- req_addr  in  64*NUM_REQ  byte address.
- ari_enabled  in  1  selects the ARI Requester ID format.
- bus_num  in  8  bus number.
- device_num  in  5  device number (non-ARI).
- fnc_num  in  3  function number (non-ARI).
- ari_fnc_num  in  8  function number (ARI).
- fc_ph_limit  in  CRED_W  posted header credit limit from UpdateFC.
- fc_nph_limit  in  CRED_W  non-posted header credit limit.
- tx_dw_data  out  32  header DW.
- tx_dw_valid  out  1  DW valid.
- tx_dw_ready  in  1  downstream accept.
- tx_dw_sop  out  1  first header DW.
- tx_dw_eop  out  1  last header DW.
- tx_is_4dw  out  1  current TLP has a 4DW header.

Behaviour:
- Reset (rst==0 at a clk edge):
  - state=IDLE; all outputs 0.
  - Consumed credit counters PH and NPH = 0; tag counter = 0.
  - Round-robin pointer set so requester 0 has highest priority.
  - Reset mid-TLP abandons the header; no eop is emitted.
- Credit eligibility, computed mod 2^CRED_W:
  - Eligible when (limit - consumed) is in 1..2^(CRED_W-1).
  - Posted requests use PH; non-posted requests use NPH.
  - A requester is eligible when req_valid is high and its credit class is eligible.
- States: IDLE, DW0, DW1, DW2, DW3.
- IDLE:
  - With any requester eligible, grant one by round robin, starting after the last granted index.
  - req_ready[g]=1 combinationally in that same cycle.
  - Latch all fields of the granted requester.
  - Consumed counter of the granted class +1.
  - If non-posted: use the current tag, then tag counter +1, wrapping TAG_MAX->0. Posted: tag=0.
  - Next state DW0. Pointer = g.
- DW0:
  - {fmt, type, T9=0, TC=000, T8=0, Attr2=0, LN=0, TH=0, TD=0, EP=0, Attr=00, AT=00, length}.
  - sop=1.
- DW1:
  - {requester_id[15:0], tag[7:0], be[7:0]}.
  - requester_id = ari_enabled ? {bus_num, ari_fnc_num} : {bus_num, device_num, fnc_num}.
  - ID fields are sampled at grant.
- Address DWs:
  - 4DW when fmt[0]==1: DW2 = addr[63:32], then DW3 = {addr[31:2], 2'b00}.
  - 3DW: DW2 = {addr[31:2], 2'b00}, and DW2 carries eop.
- Handshake:
  - Each state holds tx_dw_data, tx_dw_valid, sop and eop stable until tx_dw_ready==1.
  - The state advances on the cycle with tx_dw_valid && tx_dw_ready.
  - After the eop DW is accepted, return to IDLE.
- Throughput: one IDLE cycle between TLPs. Minimum 4 cycles per 3DW TLP, 5 cycles per 4DW TLP.
- Grant restrictions: no grant outside IDLE; req_ready is 0 in every non-IDLE state.
- Limit changes: fc_*_limit may change on any cycle and takes effect on the next IDLE evaluation.
- No eligible requester: stay in IDLE, outputs 0.

Optional Feature:
- TLP_TX_FIXED_PRIO_EN defined: fixed priority; the lowest eligible index always wins and the pointer is unused.
- Undefined: round robin as described in Behaviour.

Test Plan:
1. 3DW MWr:
   - Stimulus: req0 posted, fmt=010, type=00000, len=4, be=0xFF, addr=0x1000_0000, bus=0x01, dev=2, fn=3, ari_enabled=0, limits ample.
   - Response: DW0=0x4000_0004 (sop), DW1=0x0113_00FF, DW2=0x1000_0000 (eop).
2. 4DW MRd:
   - Stimulus: req1 non-posted, fmt=001, len=1, be=0x0F, addr=0x1_2345_6788, ari_enabled=1, ari_fnc=0xA5, bus=0x01.
   - Response: DW0=0x2000_0001, DW1=0x01A5_000F, DW2=0x0000_0001, DW3=0x2345_6788 (eop), tx_is_4dw=1.
   - A second MRd then carries tag 0x01.
3. Round robin:
   - Stimulus: req0..req3 held valid with ample credits.
   - Response: grant order 0,1,2,3,0.
   - With TLP_TX_FIXED_PRIO_EN: 0,0,0.
4. Credits:
   - Stimulus: after reset fc_nph_limit=2, two non-posted requesters plus one posted requester pending.
   - Response: two NP grants, then the posted request is granted while NP is blocked.
   - Raising fc_nph_limit to 3 yields the third NP grant.
5. Backpressure:
   - Stimulus: tx_dw_ready=0 for 5 cycles while DW1 is presented.
   - Response: DW1 stays stable and valid, all req_ready=0, DW2 follows one cycle after ready returns.
6. Reset mid-op:
   - Stimulus: rst=0 during DW2 of a 4DW TLP.
   - Response: next cycle tx_dw_valid=0, no eop; a following NP request gets tag 0 and sees the NPH counter at 0.
